// File: rtl/alu_div.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional signed operation is enabled by defining ALU_DIV_SIGNED_EN (adds port is_signed).
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ALU_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  // Handshake: start is accepted only in IDLE (operands captured on that edge); busy is
  // high while iterating; done pulses for one cycle with Q/R/div_by_zero valid and held.
  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_r;
  logic               r_dbz;
  logic               w_accept;
  logic [WIDTH:0]     w_rem_ext;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_dvd_nxt;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_accept = (r_state == S_IDLE) && start;

  // Trial subtraction is WIDTH+1 bits wide so the shifted remainder never overflows.
  assign w_rem_ext = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_rem_ext - {1'b0, r_div};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_ext[WIDTH-1:0];
  assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ge};

`ifdef ALU_DIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = is_signed & A[WIDTH-1];
  assign w_b_neg = is_signed & B[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~A + 1'b1) : A;
  assign w_b_mag = w_b_neg ? (~B + 1'b1) : B;
  assign w_q_fix = r_neg_q ? (~w_dvd_nxt + 1'b1) : w_dvd_nxt;
  assign w_r_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  assign w_a_mag = A;
  assign w_b_mag = B;
  assign w_q_fix = w_dvd_nxt;
  assign w_r_fix = w_rem_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (B == '0) ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_BUSY);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      if (B == '0) begin
        r_q   <= '1;
        r_r   <= A;
        r_dbz <= 1'b1;
      end else begin
        r_dvd <= w_a_mag;
        r_div <= w_b_mag;
        r_rem <= '0;
        r_cnt <= CNT_W'(WIDTH);
      end
    end else if (r_state == S_BUSY) begin
      r_dvd <= w_dvd_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_q   <= w_q_fix;
        r_r   <= w_r_fix;
        r_dbz <= 1'b0;
      end
    end
  end

  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule
